// File: rtl/alu_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_sequencer
// Purpose  : Registered, handshaked ALU function decoder. Accepts one decode
//            request at a time, holds the control word for a programmable
//            number of execute cycles on mult/div, and presents the result
//            with a valid/ready handshake.
// Ports    : clock, reset (async, active-high)
//            in_valid / in_ready        - request handshake
//            Function_code, ALU_optcode - request payload
//            out_valid / out_ready      - result handshake
//            ALU_control, illegal       - registered result
//            busy                       - multi-cycle execute in progress
//            retire_count               - results handed off since reset
// Revision : 1.0  initial release
// ============================================================================
module alu_ctrl_sequencer #(
   parameter int FUNCT_W     = 6,
   parameter int CTRL_W      = 4,
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 8,
   parameter int CNT_W       = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [FUNCT_W-1:0] Function_code,
   input  logic               ALU_optcode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CTRL_W-1:0]  ALU_control,
   output logic               illegal,
   output logic               busy,
   output logic [CNT_W-1:0]   retire_count
);

   localparam int C_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   // A single-cycle worst case would give a zero-width counter; keep one bit.
   localparam int C_CNT_W   = (C_MAX_CYC > 1) ? $clog2(C_MAX_CYC) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [C_CNT_W-1:0]   r_cnt;
   logic [CTRL_W-1:0]    r_ctrl;
   logic                 r_ill;
   logic [CNT_W-1:0]     r_retire;

   logic [3:0]           w_dec_ctrl;
   logic                 w_dec_ill;
   logic                 w_dec_multi;
   logic                 w_dec_div;
   logic                 w_accept;
   logic                 w_retire;
   logic                 w_in_ready;

   // ------------------------------------------------------------------------
   // Decode of the incoming request. Undefined codes force 0000 so nothing
   // stale from an earlier request can leak into the result.
   // ------------------------------------------------------------------------
   always_comb begin
      w_dec_ctrl  = 4'b0000;
      w_dec_ill   = 1'b0;
      w_dec_multi = 1'b0;
      w_dec_div   = 1'b0;
      if (!ALU_optcode) begin
         case (Function_code)
            FUNCT_W'(6'b100000): w_dec_ctrl = 4'b0000;
            FUNCT_W'(6'b100010): w_dec_ctrl = 4'b0001;
            FUNCT_W'(6'b011000): begin
               w_dec_ctrl  = 4'b0010;
               w_dec_multi = 1'b1;
            end
            FUNCT_W'(6'b011010): begin
               w_dec_ctrl  = 4'b0011;
               w_dec_multi = 1'b1;
               w_dec_div   = 1'b1;
            end
            FUNCT_W'(6'b000000): w_dec_ctrl = 4'b0100;
            FUNCT_W'(6'b000010): w_dec_ctrl = 4'b0101;
            FUNCT_W'(6'b100100): w_dec_ctrl = 4'b1000;
            FUNCT_W'(6'b100101): w_dec_ctrl = 4'b1001;
            FUNCT_W'(6'b100110): w_dec_ctrl = 4'b1010;
            FUNCT_W'(6'b100111): w_dec_ctrl = 4'b1011;
            default:             w_dec_ill  = 1'b1;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and handshake logic. In DONE the slot frees up in the same
   // cycle the consumer takes the result, which gives zero-bubble
   // back-to-back operation.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_accept    = 1'b0;
      w_retire    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            w_accept   = in_valid;
         end
         S_EXEC: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_in_ready = out_ready;
            if (out_ready) begin
               w_retire    = 1'b1;
               w_accept    = in_valid;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_accept) begin
         w_state_nxt = w_dec_multi ? S_EXEC : S_DONE;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_ctrl   <= '0;
         r_ill    <= 1'b0;
         r_retire <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_ctrl <= CTRL_W'(w_dec_ctrl);
            r_ill  <= w_dec_ill;
         end
         // Counter is loaded with N-1 so EXEC lasts exactly N cycles.
         if (w_accept && w_dec_multi) begin
            r_cnt <= w_dec_div ? C_CNT_W'(DIV_CYCLES - 1) : C_CNT_W'(MULT_CYCLES - 1);
         end else if (r_state == S_EXEC && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_retire) begin
            r_retire <= r_retire + 1'b1;
         end
      end
   end

   assign in_ready     = w_in_ready;
   assign out_valid    = (r_state == S_DONE);
   assign busy         = (r_state == S_EXEC);
   assign ALU_control  = r_ctrl;
   assign illegal      = r_ill;
   assign retire_count = r_retire;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ctrl_sequencer
// Purpose  : Self-checking bench for alu_ctrl_sequencer. A timeline model
//            (each accepted request becomes ready at a known cycle) predicts
//            every output each cycle; directed literal checks pin the model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_sequencer;

   localparam int FUNCT_W     = 6;
   localparam int CTRL_W      = 4;
   localparam int MULT_CYCLES = 4;
   localparam int DIV_CYCLES  = 8;
   localparam int CNT_W       = 2;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [FUNCT_W-1:0] Function_code = '0;
   logic               ALU_optcode = 1'b0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [CTRL_W-1:0]  ALU_control;
   logic               illegal;
   logic               busy;
   logic [CNT_W-1:0]   retire_count;

   int total = 0;
   int bad   = 0;

   // Model state: a pending result becomes visible at cycle m_rdy.
   bit          m_pend;
   longint      m_rdy;
   longint      m_cyc;
   logic [3:0]  m_ctrl;
   logic        m_ill;
   int          m_ret;

   alu_ctrl_sequencer #(
      .FUNCT_W    (FUNCT_W),
      .CTRL_W     (CTRL_W),
      .MULT_CYCLES(MULT_CYCLES),
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .Function_code(Function_code),
      .ALU_optcode  (ALU_optcode),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .ALU_control  (ALU_control),
      .illegal      (illegal),
      .busy         (busy),
      .retire_count (retire_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference decode straight from the opcode table.
   task automatic ref_decode(input logic [5:0] fc, input logic op,
                             output logic [3:0] ctrl, output logic ill, output int lat);
      ctrl = 4'h0; ill = 1'b0; lat = 0;
      if (!op) begin
         case (fc)
            6'b100000: ctrl = 4'h0;
            6'b100010: ctrl = 4'h1;
            6'b011000: begin ctrl = 4'h2; lat = MULT_CYCLES; end
            6'b011010: begin ctrl = 4'h3; lat = DIV_CYCLES; end
            6'b000000: ctrl = 4'h4;
            6'b000010: ctrl = 4'h5;
            6'b100100: ctrl = 4'h8;
            6'b100101: ctrl = 4'h9;
            6'b100110: ctrl = 4'hA;
            6'b100111: ctrl = 4'hB;
            default:   ill  = 1'b1;
         endcase
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_rdy = 0; m_cyc = 0;
      m_ctrl = 4'h0; m_ill = 1'b0; m_ret = 0;
   endtask

   function automatic bit exp_out_valid();
      return m_pend && (m_cyc >= m_rdy);
   endfunction

   // Advance the model by one clock edge using the inputs seen at that edge.
   task automatic model_step();
      bit         ov, ir;
      logic [3:0] c;
      logic       il;
      int         lat;
      ov = exp_out_valid();
      ir = !m_pend || (ov && out_ready);
      if (ov && out_ready) begin
         m_ret  = (m_ret + 1) % (1 << CNT_W);
         m_pend = 0;
      end
      if (in_valid && ir) begin
         ref_decode(Function_code, ALU_optcode, c, il, lat);
         m_ctrl = c; m_ill = il; m_pend = 1;
         m_rdy  = m_cyc + 1 + lat;
      end
      m_cyc++;
   endtask

   task automatic compare_all();
      bit ov;
      ov = exp_out_valid();
      chk("out_valid",    32'(out_valid),    32'(ov));
      chk("busy",         32'(busy),         32'(m_pend && !ov));
      chk("in_ready",     32'(in_ready),     32'(!m_pend || (ov && out_ready)));
      chk("ALU_control",  32'(ALU_control),  32'(m_ctrl));
      chk("illegal",      32'(illegal),      32'(m_ill));
      chk("retire_count", 32'(retire_count), 32'(m_ret));
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic drive(input logic iv, input logic [5:0] fc, input logic op, input logic ordy);
      in_valid = iv; Function_code = fc; ALU_optcode = op; out_ready = ordy;
      #1;
      compare_all();
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear without a clock.
   task automatic mid_reset();
      #3 reset = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid),    32'd0);
      chk("rst_busy",      32'(busy),         32'd0);
      chk("rst_ctrl",      32'(ALU_control),  32'd0);
      chk("rst_illegal",   32'(illegal),      32'd0);
      chk("rst_retire",    32'(retire_count), 32'd0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      model_reset();
   endtask

   logic [5:0] legal_fc [10] = '{6'b100000, 6'b100010, 6'b011000, 6'b011010, 6'b000000,
                                 6'b000010, 6'b100100, 6'b100101, 6'b100110, 6'b100111};
   int         wrap_seq [5]  = '{1, 2, 3, 0, 1};

   initial begin
      model_reset();
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      chk("reset_out_valid", 32'(out_valid),    32'd0);
      chk("reset_busy",      32'(busy),         32'd0);
      chk("reset_ctrl",      32'(ALU_control),  32'd0);
      chk("reset_illegal",   32'(illegal),      32'd0);
      chk("reset_retire",    32'(retire_count), 32'd0);

      // Single-cycle sub
      drive(1'b1, 6'b100010, 1'b0, 1'b1);
      chk("sub_valid", 32'(out_valid),   32'd1);
      chk("sub_ctrl",  32'(ALU_control), 32'h1);
      chk("sub_ill",   32'(illegal),     32'd0);
      drive(1'b0, 6'b000000, 1'b0, 1'b1);
      chk("sub_retire", 32'(retire_count), 32'd1);
      chk("sub_idle",   32'(out_valid),    32'd0);

      // mult: busy for exactly MULT_CYCLES cycles
      drive(1'b1, 6'b011000, 1'b0, 1'b1);
      for (int k = 0; k < MULT_CYCLES; k++) begin
         chk("mult_busy",  32'(busy),        32'd1);
         chk("mult_rdy",   32'(in_ready),    32'd0);
         chk("mult_ctrl",  32'(ALU_control), 32'h2);
         drive(1'b0, 6'b000000, 1'b0, 1'b1);
      end
      chk("mult_valid",   32'(out_valid), 32'd1);
      chk("mult_nobusy",  32'(busy),      32'd0);
      drive(1'b0, 6'b000000, 1'b0, 1'b1);

      // Illegal code, then optcode override on a div code
      drive(1'b1, 6'b111111, 1'b0, 1'b1);
      chk("ill_ctrl",  32'(ALU_control), 32'h0);
      chk("ill_flag",  32'(illegal),     32'd1);
      chk("ill_valid", 32'(out_valid),   32'd1);
      chk("ill_busy",  32'(busy),        32'd0);
      drive(1'b1, 6'b011010, 1'b1, 1'b1);
      chk("ovr_ctrl",  32'(ALU_control), 32'h0);
      chk("ovr_ill",   32'(illegal),     32'd0);
      chk("ovr_busy",  32'(busy),        32'd0);
      chk("ovr_valid", 32'(out_valid),   32'd1);

      // Back-pressure for 3 cycles, then back-to-back or
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 6'b100000, 1'b0, 1'b0);
         chk("bp_valid", 32'(out_valid),   32'd1);
         chk("bp_ctrl",  32'(ALU_control), 32'h0);
         chk("bp_rdy",   32'(in_ready),    32'd0);
      end
      drive(1'b1, 6'b100101, 1'b0, 1'b1);
      chk("b2b_ctrl",  32'(ALU_control), 32'h9);
      chk("b2b_valid", 32'(out_valid),   32'd1);
      drive(1'b0, 6'b000000, 1'b0, 1'b1);

      // Reset during div execute
      drive(1'b1, 6'b011010, 1'b0, 1'b1);
      drive(1'b0, 6'b000000, 1'b0, 1'b1);
      drive(1'b0, 6'b000000, 1'b0, 1'b1);
      chk("div_busy", 32'(busy), 32'd1);
      mid_reset();
      chk("div_rst_retire", 32'(retire_count), 32'd0);

      // retire_count wrap with CNT_W=2
      drive(1'b1, 6'b100000, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         drive((i < 4) ? 1'b1 : 1'b0, 6'b100000, 1'b0, 1'b1);
         chk("wrap_retire", 32'(retire_count), 32'(wrap_seq[i]));
      end

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         logic [5:0] fc;
         if ($urandom_range(0, 9) < 7) fc = legal_fc[$urandom_range(0, 9)];
         else                          fc = 6'($urandom);
         if ($urandom_range(0, 399) == 0) begin
            mid_reset();
         end else begin
            drive(($urandom_range(0, 3) != 0), fc, ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_sequencer.md
Name: alu_ctrl_sequencer

Overview:
- Registered, handshaked successor to the combinational ALU function decoder.
- Accepts one decode request at a time: Function_code plus ALU_optcode.
- Produces a stable ALU_control word and flags illegal function codes.
- For multi-cycle ops (mult, div), holds the control word for a parametrised number of execute cycles before presenting the result to the writeback stage.

Parameters:
- FUNCT_W, 6: width of Function_code.
- CTRL_W, 4: width of ALU_control (minimum 4).
- MULT_CYCLES, 4: execute cycles for mult (legal range 1..255).
- DIV_CYCLES, 8: execute cycles for div (legal range 1..255).
- CNT_W, 16: width of retire_count.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- Function_code  in  FUNCT_W  R-type function field.
- ALU_optcode  in  1  1 = force add (loads, stores, immediates); Function_code ignored.
- out_valid  out  1  ALU_control and illegal are final.
- out_ready  in  1  consumer accepts the result.
- ALU_control  out  CTRL_W  registered control word.
- illegal  out  1  latched request had an undefined Function_code.
- busy  out  1  multi-cycle execute in progress.
- retire_count  out  CNT_W  results handed off since reset; wraps.

Behaviour:
- Decode table:
  - ALU_optcode=1 -> add 0000.
  - Otherwise by Function_code: 100000 add 0000; 100010 sub 0001; 011000 mult 0010; 011010 div 0011; 000000 sll 0100; 000010 srl 0101; 100100 and 1000; 100101 or 1001; 100110 xor 1010; 100111 nor 1011.
  - Any other code -> ALU_control=0000, illegal=1. The block never holds a stale value on an undefined code.
  - Control codes are zero-extended to CTRL_W.
- Reset, asynchronous and immediate:
  - State=IDLE; ALU_control=0, illegal=0, out_valid=0, busy=0, retire_count=0, internal counter=0.
  - Reset asserted mid-EXEC aborts the operation. No result is produced.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch the decoded control and illegal.
  - Legal mult or div -> EXEC, counter loaded with MULT_CYCLES-1 or DIV_CYCLES-1.
  - Anything else, including illegal codes -> DONE.
- EXEC:
  - in_ready=0, busy=1, out_valid=0. ALU_control held.
  - Counter decrements each cycle. At counter==0 -> DONE.
- DONE:
  - out_valid=1, busy=0, outputs held until out_ready.
  - in_ready = out_ready.
  - On out_ready=1: retire_count increments, wrapping at 2^CNT_W.
    - If in_valid=1 in the same cycle, the new request is decoded exactly as in IDLE (back-to-back, zero bubble).
    - Otherwise -> IDLE.
  - On out_ready=0: remain in DONE. Outputs must not change.
- Latency, measured from the accepting edge:
  - Single-cycle ops: out_valid high after 1 cycle.
  - mult: out_valid after MULT_CYCLES+1 cycles.
  - div: out_valid after DIV_CYCLES+1 cycles.
- Throughput: 1 single-cycle op per cycle while out_ready stays high.
- in_valid while in_ready=0 is ignored. The source must hold the request stable.
- ALU_control and illegal change only on an accepting edge or reset.
- Counter width is clog2(max(MULT_CYCLES, DIV_CYCLES)).

Test Plan:
1. Reset then single op: in_valid=1, Function_code=100010, optcode=0, out_ready=1 -> next cycle out_valid=1, ALU_control=0001, illegal=0, retire_count=1 after handoff.
2. Multi-cycle mult: Function_code=011000 with MULT_CYCLES=4 -> busy=1 for exactly 4 cycles, in_ready=0 throughout, out_valid at cycle 5, ALU_control=0010 stable from acceptance.
3. Illegal and override: Function_code=111111 -> ALU_control=0000, illegal=1, no EXEC. Then optcode=1 with Function_code=011010 -> 0000, no busy.
4. Back-pressure and back-to-back: hold out_ready=0 for 3 cycles in DONE -> outputs frozen, in_ready=0. Then out_ready=1 with in_valid=1 carrying 100101 -> next cycle ALU_control=1001, out_valid=1, no bubble.
5. Reset mid-div: DIV_CYCLES=8, assert reset at EXEC cycle 3 -> all outputs 0 immediately, state IDLE, retire_count unchanged at 0.
6. Wrap: CNT_W=2, retire 5 ops -> retire_count sequence 1,2,3,0,1.
